// File: rtl/bldc_pkg.sv
// Shared types for the BLDC gate stage: leg FSM states, leg requests, pair codes.
// Combinational helper only. Latency: none. Backpressure: none.
package bldc_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE_H, DRIVE_L, DEAD} leg_state_t;
  typedef enum logic [1:0] {REQ_OFF, REQ_H, REQ_L} leg_req_t;

  localparam logic [1:0] PAIR_H   = 2'b10;
  localparam logic [1:0] PAIR_L   = 2'b01;
  localparam logic [1:0] PAIR_BAD = 2'b11;

  // Low side is never modulated; a bad pair falls through to REQ_OFF.
  function automatic leg_req_t decodePair(input logic [1:0] pair, input logic enable,
                                          input logic pwmOn);
    leg_req_t req;
    req = REQ_OFF;
    if (enable) begin
      if (pair == PAIR_H && pwmOn) req = REQ_H;
      else if (pair == PAIR_L)     req = REQ_L;
    end
    return req;
  endfunction

endpackage

// File: rtl/bldc_deadtime_leg.sv
// One half-bridge leg: follows the request, forcing DEADTIME low clocks after every gate-off.
// Latency: 1 clock from request to gate. Backpressure: none, request is sampled every clock.
module bldc_deadtime_leg
  import bldc_pkg::*;
#(
  parameter int DEADTIME = 24
) (
  input  logic     iCLK,
  input  logic     iRESET,
  input  leg_req_t iReq,
  output logic     oGateH,
  output logic     oGateL
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME - 1);

  leg_state_t state;
  logic [7:0] deadCnt;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state   <= IDLE;
      deadCnt <= '0;
      oGateH  <= 1'b0;
      oGateL  <= 1'b0;
    end else begin
      case (state)
        IDLE, DEAD: begin
          // DEAD releases straight into the current request once the counter hits zero.
          if (state == IDLE || deadCnt == 8'd0) begin
            case (iReq)
              REQ_H: begin
                state  <= DRIVE_H;
                oGateH <= 1'b1;
              end
              REQ_L: begin
                state  <= DRIVE_L;
                oGateL <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end else begin
            deadCnt <= deadCnt - 8'd1;
          end
        end
        DRIVE_H: begin
          if (iReq != REQ_H) begin
            state   <= DEAD;
            deadCnt <= DEAD_LOAD;
            oGateH  <= 1'b0;
          end
        end
        DRIVE_L: begin
          if (iReq != REQ_L) begin
            state   <= DEAD;
            deadCnt <= DEAD_LOAD;
            oGateL  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          oGateH <= 1'b0;
          oGateL <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bldc_pwm_gate.sv
// Six-step gate driver: carrier, shadowed duty, per-leg request decode, sticky fault, 3 dead-time legs.
// Latency: 1 clock from pattern/enable to gates. Backpressure: none, inputs sampled every clock.
module bldc_pwm_gate
  import bldc_pkg::*;
#(
  parameter int PWM_BITS = 11,
  parameter int PERIOD   = 1200,
  parameter int DEADTIME = 24
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iENABLE,
  input  logic [5:0]          iPHASES,
  input  logic [PWM_BITS-1:0] iDUTY,
  output logic [5:0]          oGATES,
  output logic                oPWM_SYNC,
  output logic                oFAULT
);

  localparam logic [PWM_BITS-1:0] LAST_COUNT = PWM_BITS'(PERIOD - 1);

  logic [PWM_BITS-1:0] carrierCnt;
  logic [PWM_BITS-1:0] nextCnt;
  logic [PWM_BITS-1:0] dutyShadow;
  logic                pwmOn;
  logic                patternBad;

  assign nextCnt    = (carrierCnt == LAST_COUNT) ? '0 : carrierCnt + PWM_BITS'(1);
  // Shadow at or above PERIOD saturates to always-on because the count never reaches it.
  assign pwmOn      = carrierCnt < dutyShadow;
  assign patternBad = (iPHASES[5:4] == PAIR_BAD) || (iPHASES[3:2] == PAIR_BAD) ||
                      (iPHASES[1:0] == PAIR_BAD);

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      carrierCnt <= '0;
      dutyShadow <= '0;
      oPWM_SYNC  <= 1'b0;
      oFAULT     <= 1'b0;
    end else begin
      carrierCnt <= nextCnt;
      oPWM_SYNC  <= (nextCnt == '0);
      if (carrierCnt == LAST_COUNT) dutyShadow <= iDUTY;
      // Disable wins over a simultaneous bad pattern.
      if (!iENABLE)        oFAULT <= 1'b0;
      else if (patternBad) oFAULT <= 1'b1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : gLeg
    leg_req_t legReq;
    assign legReq = decodePair(iPHASES[2*k+1:2*k], iENABLE, pwmOn);

    bldc_deadtime_leg #(
      .DEADTIME(DEADTIME)
    ) uLeg (
      .iCLK  (iCLK),
      .iRESET(iRESET),
      .iReq  (legReq),
      .oGateH(oGATES[2*k+1]),
      .oGateL(oGATES[2*k])
    );
  end

endmodule

// File: tb/tb_bldc_pwm_gate.sv
// Bench for bldc_pwm_gate: timestamp-based reference model plus directed and random scenarios.
module tb_bldc_pwm_gate;

  localparam int PWM_BITS = 11;
  localparam int PERIOD   = 1200;
  localparam int DEADTIME = 24;

  logic                iCLK = 1'b0;
  logic                iRESET;
  logic                iENABLE;
  logic [5:0]          iPHASES;
  logic [PWM_BITS-1:0] iDUTY;
  logic [5:0]          oGATES;
  logic                oPWM_SYNC;
  logic                oFAULT;

  int total = 0;
  int bad   = 0;

  // Reference model state: expected outputs for the current cycle.
  int      mCount, mShadow;
  logic    mSync, mFault;
  logic [5:0] mGates;
  int      legGate [3];     // 0 none, 1 high side, 2 low side; index 0 = leg A
  longint  legOffEdge [3];  // edge number at which that leg last dropped a gate
  longint  edgeN;

  always #5 iCLK = ~iCLK;

  bldc_pwm_gate #(
    .PWM_BITS(PWM_BITS),
    .PERIOD  (PERIOD),
    .DEADTIME(DEADTIME)
  ) dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iENABLE  (iENABLE),
    .iPHASES  (iPHASES),
    .iDUTY    (iDUTY),
    .oGATES   (oGATES),
    .oPWM_SYNC(oPWM_SYNC),
    .oFAULT   (oFAULT)
  );

  task automatic modelReset();
    mCount = 0; mShadow = 0; mSync = 1'b0; mFault = 1'b0; mGates = 6'b0; edgeN = 0;
    for (int k = 0; k < 3; k++) begin
      legGate[k]    = 0;
      legOffEdge[k] = -1000000;
    end
  endtask

  // Advance the model by one clock edge from the current inputs, then let the DUT take the same edge.
  task automatic step();
    int   pair, req;
    logic anyBad, pwmOn;
    pwmOn  = (mCount < mShadow);
    anyBad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pair = int'((iPHASES >> (4 - 2*k)) & 6'd3);
      if (pair == 3) anyBad = 1'b1;
      if (!iENABLE || pair == 3) req = 0;
      else if (pair == 2)        req = pwmOn ? 1 : 0;
      else if (pair == 1)        req = 2;
      else                       req = 0;
      if (legGate[k] != 0) begin
        if (req != legGate[k]) begin
          legGate[k]    = 0;
          legOffEdge[k] = edgeN;
        end
      end else if (edgeN - legOffEdge[k] >= DEADTIME) begin
        legGate[k] = req;
      end
      mGates[5-2*k] = (legGate[k] == 1);
      mGates[4-2*k] = (legGate[k] == 2);
    end
    mFault = iENABLE ? (mFault | anyBad) : 1'b0;
    if (mCount == PERIOD - 1) begin
      mShadow = int'(iDUTY);
      mCount  = 0;
    end else begin
      mCount++;
    end
    mSync = (mCount == 0);
    edgeN++;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    iRESET = 1'b1; iENABLE = 1'b0; iPHASES = 6'b0; iDUTY = '0;
    repeat (3) @(negedge iCLK);
    total++; if (oGATES !== 6'b0)  begin bad++; $display("FAIL reset_gates got=%b exp=000000", oGATES); end
    total++; if (oPWM_SYNC !== 1'b0) begin bad++; $display("FAIL reset_sync got=%b exp=0", oPWM_SYNC); end
    total++; if (oFAULT !== 1'b0)  begin bad++; $display("FAIL reset_fault got=%b exp=0", oFAULT); end
    iRESET = 1'b0;
    modelReset();
  endtask

  task automatic test_pwm_basic();
    int hi, lo, syncs;
    iENABLE = 1'b1; iPHASES = 6'b100100; iDUTY = 11'd600;
    for (int i = 0; i < 2*PERIOD; i++) begin
      step();
      total++;
      if ({oGATES, oPWM_SYNC, oFAULT} !== {mGates, mSync, mFault}) begin
        bad++; $display("FAIL basic_model got=%b/%b/%b exp=%b/%b/%b", oGATES, oPWM_SYNC, oFAULT, mGates, mSync, mFault);
      end
    end
    hi = 0; lo = 0; syncs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      hi    += int'(oGATES[5]);
      lo    += int'(oGATES[2]);
      syncs += int'(oPWM_SYNC);
    end
    total++; if (hi != 600)    begin bad++; $display("FAIL basic_high_time got=%0d exp=600", hi); end
    total++; if (lo != PERIOD) begin bad++; $display("FAIL basic_low_side got=%0d exp=%0d", lo, PERIOD); end
    total++; if (syncs != 1)   begin bad++; $display("FAIL basic_sync_count got=%0d exp=1", syncs); end
  endtask

  task automatic test_commutation();
    int n;
    iDUTY = 11'd1200;
    n = 0;
    while (!(mShadow == 1200 && mCount == 5) && n < 3000) begin
      step(); n++;
    end
    total++; if (oGATES !== 6'b100100) begin bad++; $display("FAIL comm_before got=%b exp=100100", oGATES); end
    iPHASES = 6'b011000;
    step();
    n = 0;
    while (oGATES === 6'b0 && n < 100) begin
      n++; step();
    end
    total++; if (n != DEADTIME)        begin bad++; $display("FAIL comm_dead_len got=%0d exp=%0d", n, DEADTIME); end
    total++; if (oGATES !== 6'b011000) begin bad++; $display("FAIL comm_after got=%b exp=011000", oGATES); end
    total++; if (oGATES !== mGates)    begin bad++; $display("FAIL comm_model got=%b exp=%b", oGATES, mGates); end
  endtask

  task automatic test_duty_shadow();
    int n, hi;
    iPHASES = 6'b100100; iDUTY = 11'd300;
    n = 0;
    while (!(mShadow == 300 && mCount == 1) && n < 3000) begin
      step(); n++;
    end
    for (int w = 0; w < 2; w++) begin
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
        hi += int'(oGATES[5]);
        if (w == 0 && mCount == 100) iDUTY = 11'd900;
        total++;
        if ({oGATES, oPWM_SYNC, oFAULT} !== {mGates, mSync, mFault}) begin
          bad++; $display("FAIL shadow_model got=%b/%b/%b exp=%b/%b/%b", oGATES, oPWM_SYNC, oFAULT, mGates, mSync, mFault);
        end
        step();
      end
      total++;
      if (hi != (w == 0 ? 300 : 900)) begin
        bad++; $display("FAIL shadow_on_time window=%0d got=%0d exp=%0d", w, hi, (w == 0 ? 300 : 900));
      end
    end
  endtask

  task automatic test_min_pulse();
    int   n, hi, rises, run, minOff, runs;
    logic prev;
    iPHASES = 6'b100100; iDUTY = 11'd10;
    n = 0;
    while (!(mShadow == 10 && mCount == 1) && n < 3000) begin
      step(); n++;
    end
    hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 10*PERIOD; i++) begin
      hi += int'(oGATES[5]);
      if (oGATES[5] && !prev) rises++;
      prev = oGATES[5];
      total++;
      if ((oGATES & (oGATES >> 1) & 6'b010101) !== 6'b0) begin
        bad++; $display("FAIL min_overlap gates=%b", oGATES);
      end
      total++;
      if (oGATES !== mGates) begin bad++; $display("FAIL min_model got=%b exp=%b", oGATES, mGates); end
      step();
    end
    total++; if (hi != 100)   begin bad++; $display("FAIL min_high_total got=%0d exp=100", hi); end
    total++; if (rises != 10) begin bad++; $display("FAIL min_pulses got=%0d exp=10", rises); end
    // Off-interval of 10 clocks must be stretched to the dead time.
    iDUTY = 11'd1190;
    n = 0;
    while (!(mShadow == 1190 && mCount == 1) && n < 3000) begin
      step(); n++;
    end
    run = -1; minOff = 100000; runs = 0; prev = oGATES[5];
    for (int i = 0; i < 2*PERIOD; i++) begin
      if (!oGATES[5] && prev)        run = 1;
      else if (!oGATES[5] && run > 0) run++;
      else if (oGATES[5] && run > 0) begin
        if (run < minOff) minOff = run;
        runs++; run = -1;
      end
      prev = oGATES[5];
      step();
    end
    total++; if (runs < 1)          begin bad++; $display("FAIL min_stretch_runs got=%0d exp>=1", runs); end
    total++; if (minOff != DEADTIME) begin bad++; $display("FAIL min_stretch_len got=%0d exp=%0d", minOff, DEADTIME); end
  endtask

  task automatic test_fault();
    iENABLE = 1'b1; iPHASES = 6'b110000;
    step();
    total++; if (oFAULT !== 1'b1)        begin bad++; $display("FAIL fault_set got=%b exp=1", oFAULT); end
    total++; if (oGATES[5:4] !== 2'b00)  begin bad++; $display("FAIL fault_legA got=%b exp=00", oGATES[5:4]); end
    iPHASES = 6'b100100;
    for (int i = 0; i < 50; i++) begin
      step();
      total++;
      if ({oGATES, oFAULT} !== {mGates, mFault}) begin
        bad++; $display("FAIL fault_model got=%b/%b exp=%b/%b", oGATES, oFAULT, mGates, mFault);
      end
    end
    total++; if (oFAULT !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b exp=1", oFAULT); end
    iENABLE = 1'b0;
    step();
    total++; if (oFAULT !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", oFAULT); end
    total++; if (oGATES !== 6'b0) begin bad++; $display("FAIL fault_disable_gates got=%b exp=000000", oGATES); end
    iPHASES = 6'b110000;
    step();
    total++; if (oFAULT !== 1'b0) begin bad++; $display("FAIL fault_ignored_when_off got=%b exp=0", oFAULT); end
    iENABLE = 1'b1; iPHASES = 6'b100100;
    step();
    total++; if (oFAULT !== 1'b0) begin bad++; $display("FAIL fault_reenable got=%b exp=0", oFAULT); end
  endtask

  task automatic test_async_reset();
    int n, hi;
    iENABLE = 1'b1; iPHASES = 6'b100100; iDUTY = 11'd1200;
    n = 0;
    while (!(mShadow == 1200 && mCount == 400) && n < 3000) begin
      step(); n++;
    end
    total++; if (oGATES[5] !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", oGATES[5]); end
    #2 iRESET = 1'b1;
    #1;
    total++; if (oGATES !== 6'b0)    begin bad++; $display("FAIL areset_gates got=%b exp=000000", oGATES); end
    total++; if (oPWM_SYNC !== 1'b0) begin bad++; $display("FAIL areset_sync got=%b exp=0", oPWM_SYNC); end
    @(negedge iCLK);
    iRESET = 1'b0; iDUTY = 11'd600;
    modelReset();
    for (int w = 0; w < 2; w++) begin
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
        step();
        hi += int'(oGATES[5]);
        total++;
        if ({oGATES, oPWM_SYNC, oFAULT} !== {mGates, mSync, mFault}) begin
          bad++; $display("FAIL areset_model got=%b/%b/%b exp=%b/%b/%b", oGATES, oPWM_SYNC, oFAULT, mGates, mSync, mFault);
        end
      end
      total++;
      if (hi != (w == 0 ? 0 : 600)) begin
        bad++; $display("FAIL areset_high window=%0d got=%0d exp=%0d", w, hi, (w == 0 ? 0 : 600));
      end
    end
  endtask

  task automatic test_random();
    int hold, p;
    logic [5:0] pat;
    for (int seg = 0; seg < 40; seg++) begin
      pat = 6'b0;
      for (int k = 0; k < 3; k++) begin
        p = $urandom_range(0, 2);
        pat = pat | (6'(p == 1 ? 2 : (p == 2 ? 1 : 0)) << (2*k));
      end
      if ($urandom_range(0, 9) == 0) pat[3:2] = 2'b11;
      iPHASES = pat;
      iENABLE = ($urandom_range(0, 9) != 0);
      iDUTY   = PWM_BITS'($urandom_range(0, 2047));
      hold    = $urandom_range(1, 300);
      for (int i = 0; i < hold; i++) begin
        step();
        total++;
        if ({oGATES, oPWM_SYNC, oFAULT} !== {mGates, mSync, mFault}) begin
          bad++; $display("FAIL random_model seg=%0d got=%b/%b/%b exp=%b/%b/%b", seg, oGATES, oPWM_SYNC, oFAULT, mGates, mSync, mFault);
        end
        total++;
        if ((oGATES & (oGATES >> 1) & 6'b010101) !== 6'b0) begin
          bad++; $display("FAIL random_overlap seg=%0d gates=%b", seg, oGATES);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pwm_basic();
    test_commutation();
    test_duty_shadow();
    test_min_pulse();
    test_fault();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
